cache_mgmt_unit: RTL

- Controller FSM for the 2-way set-associative write-back data cache (23-bit tag, 5-bit index, 4-word block).
- Accepts CPU load/store requests and drives the cache array's load/edit/store/invalid strobes.
- On a miss, writes back the victim block to memory when it is dirty, refills the block from memory, then replays the access.
- Sits between the CPU MEM stage and the cache array on one side, and the memory port on the other.

---
 rtl/cache_mgmt_unit.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_mgmt_unit.sv
// Controller FSM for a 2-way set-associative write-back data cache: lookup, dirty writeback, refill, replay.
// Define CMU_STATS_EN to build the hit/miss statistics counters; otherwise both counters read as zero.
module cache_mgmt_unit #(
  parameter int ADDR_BITS     = 32,
  parameter int TAG_BITS      = 23,
  parameter int INDEX_BITS    = 5,
  parameter int WORD_SEL_BITS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_en_r,
  input  logic                  cpu_en_w,
  input  logic [ADDR_BITS-1:0]  cpu_addr,
  input  logic [2:0]            cpu_u_b_h_w,
  input  logic [31:0]           cpu_data_w,
  output logic [31:0]           cpu_data_r,
  output logic                  cpu_stall,
  output logic [ADDR_BITS-1:0]  cache_addr,
  output logic                  cache_load,
  output logic                  cache_edit,
  output logic                  cache_store,
  output logic                  cache_invalid,
  output logic [2:0]            cache_u_b_h_w,
  output logic [31:0]           cache_din,
  input  logic                  cache_hit,
  input  logic [31:0]           cache_dout,
  input  logic                  cache_valid,
  input  logic                  cache_dirty,
  input  logic [TAG_BITS-1:0]   cache_tag,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [31:0]           mem_data_o,
  input  logic [31:0]           mem_data_i,
  input  logic                  mem_ack,
  output logic [31:0]           hit_cnt,
  output logic [31:0]           miss_cnt
);

  localparam int OFS = WORD_SEL_BITS + 2;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    BACK_RD,
    BACK_WR,
    FILL,
    REPLAY
  } state_t;

  state_t                         state, state_nx;
  logic [WORD_SEL_BITS-1:0]       wc, wc_nx;
  logic [TAG_BITS-1:0]            victim_tag;
  logic [ADDR_BITS-OFS-1:0]       req_line;
  logic                           req;
  logic [ADDR_BITS-1:0]           line_addr;
  logic [ADDR_BITS-1:0]           victim_addr;

  assign req           = cpu_en_r | cpu_en_w;
  assign cpu_stall     = req & ~((state == LOOKUP) & cache_hit);
  assign cache_invalid = 1'b0;

  // The block address is captured while idle so a request dropped mid-miss
  // cannot redirect the remaining refill words.
  assign line_addr   = {req_line, wc, 2'b00};
  assign victim_addr = {victim_tag, req_line[INDEX_BITS-1:0], wc, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      wc         <= '0;
      victim_tag <= '0;
      req_line   <= '0;
      cpu_data_r <= '0;
    end else begin
      state <= state_nx;
      wc    <= wc_nx;
      if (state == IDLE)
        req_line <= cpu_addr[ADDR_BITS-1:OFS];
      if (state == LOOKUP && !cache_hit && cache_valid && cache_dirty)
        victim_tag <= cache_tag;
      if (state == LOOKUP && cache_hit && cpu_en_r)
        cpu_data_r <= cache_dout;
    end
  end

  always_comb begin
    state_nx      = state;
    wc_nx         = wc;
    cache_addr    = cpu_addr;
    cache_load    = 1'b0;
    cache_edit    = 1'b0;
    cache_store   = 1'b0;
    cache_u_b_h_w = cpu_u_b_h_w;
    cache_din     = cpu_data_w;
    mem_cs        = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = line_addr;
    mem_data_o    = cache_dout;

    case (state)
      IDLE: begin
        if (req) begin
          cache_load = cpu_en_r;
          cache_edit = cpu_en_w;
          state_nx   = LOOKUP;
        end
      end

      LOOKUP: begin
        if (cache_hit) begin
          state_nx = IDLE;
        end else begin
          wc_nx    = '0;
          state_nx = (cache_valid && cache_dirty) ? BACK_RD : FILL;
        end
      end

      BACK_RD: begin
        cache_addr = line_addr;
        state_nx   = BACK_WR;
      end

      // cache_addr stays on the victim word so cache_dout remains valid
      // for the whole memory handshake.
      BACK_WR: begin
        cache_addr = line_addr;
        mem_cs     = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = victim_addr;
        if (mem_ack) begin
          if (wc == '1) begin
            wc_nx    = '0;
            state_nx = FILL;
          end else begin
            wc_nx    = wc + 1'b1;
            state_nx = BACK_RD;
          end
        end
      end

      FILL: begin
        mem_cs = 1'b1;
        if (mem_ack) begin
          cache_store   = 1'b1;
          cache_addr    = line_addr;
          cache_din     = mem_data_i;
          cache_u_b_h_w = 3'b010;
          if (wc == '1) begin
            wc_nx    = '0;
            state_nx = REPLAY;
          end else begin
            wc_nx = wc + 1'b1;
          end
        end
      end

      REPLAY: begin
        if (req) begin
          cache_load = cpu_en_r;
          cache_edit = cpu_en_w;
          state_nx   = LOOKUP;
        end else begin
          state_nx = IDLE;
        end
      end

      default: state_nx = IDLE;
    endcase
  end

`ifdef CMU_STATS_EN
  logic first_pass;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_pass <= 1'b0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      if (state == IDLE)
        first_pass <= 1'b1;
      else if (state == REPLAY)
        first_pass <= 1'b0;
      if (state == LOOKUP) begin
        if (cache_hit) begin
          if (first_pass)
            hit_cnt <= hit_cnt + 32'd1;
        end else begin
          miss_cnt <= miss_cnt + 32'd1;
        end
      end
    end
  end
`else
  assign hit_cnt  = '0;
  assign miss_cnt = '0;
`endif

endmodule
